// File: rtl/esc_pwm_axi_slave_if.sv
// AXI4-Lite bundle between a master and the ESC PWM register slave.
// The master modport drives requests; the slave modport drives responses.
interface esc_pwm_axi_slave_if #(
    parameter int AW = 4
);
    logic [AW-1:0] s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/esc_pwm_axi_slave.sv
// AXI4-Lite register file (CTRL/PERIOD/PULSE0/PULSE1) driving a 2-channel ESC PWM.
// Optional watchdog enabled by defining ESC_PWM_WATCHDOG_EN.
module esc_pwm_axi_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] RST_PERIOD         = 32'd1000000,
    parameter logic [31:0] RST_PULSE          = 32'd50000,
    parameter int unsigned WDOG_CYCLES        = 5000000
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    esc_pwm_axi_slave_if.slave       axi,
    output logic [1:0]               esc_pwm
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t       wstate_q, wstate_d;
    rstate_t       rstate_q, rstate_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]    awidx_q, awidx_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          bvalid_q, bvalid_d, arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] reg_q [4];
    logic [DW-1:0] reg_d [4];
    logic          wcommit;
    logic [DW-1:0] ctrl_rd, pul_src0, pul_src1;

    logic [31:0]   cnt_q, cnt_d, sh_per_q, sh_per_d;
    logic [31:0]   sh_pul0_q, sh_pul0_d, sh_pul1_q, sh_pul1_d;
    logic          en_q, en_d;
    logic [1:0]    pwm_q, pwm_d;
    logic          en, en_rise, run, fresh, wrap, load;
    logic [31:0]   per_now, pul0_now, pul1_now;

    assign axi.s_axi_awready = awready_q;
    assign axi.s_axi_wready  = wready_q;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bresp   = 2'b00;
    assign axi.s_axi_arready = arready_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign axi.s_axi_rresp   = 2'b00;
    assign esc_pwm           = pwm_q;

    wire unused_bus = ^{axi.s_axi_awprot, axi.s_axi_arprot,
                        axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0],
                        C_S_AXI_ADDR_WIDTH[0]};

    always_comb begin
        wstate_d  = wstate_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        wcommit   = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_done_q && w_done_q) begin
                    wcommit   = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                end else begin
                    if (axi.s_axi_awvalid && awready_q) begin
                        aw_done_d = 1'b1;
                        awidx_d   = axi.s_axi_awaddr[3:2];
                    end
                    if (axi.s_axi_wvalid && wready_q) begin
                        w_done_d = 1'b1;
                        wdata_d  = axi.s_axi_wdata;
                        wstrb_d  = axi.s_axi_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (axi.s_axi_bready) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
        endcase
        awready_d = (wstate_d == W_IDLE) && !aw_done_d;
        wready_d  = (wstate_d == W_IDLE) && !w_done_d;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];
        if (wcommit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) reg_d[awidx_q][8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (axi.s_axi_arvalid && arready_q) begin
                    rdata_d  = (axi.s_axi_araddr[3:2] == 2'd0) ? ctrl_rd
                                                               : reg_q[axi.s_axi_araddr[3:2]];
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

`ifdef ESC_PWM_WATCHDOG_EN
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_to_q, wdog_to_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q + 32'd1;
        wdog_to_d  = wdog_to_q;
        if (!en || (wcommit && awidx_q[1])) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q >= WDOG_CYCLES - 1) begin
            wdog_cnt_d = wdog_cnt_q;
            wdog_to_d  = 1'b1;
        end
        if (wcommit && awidx_q == 2'd0 && wstrb_q[3] && !wdata_q[31])
            wdog_to_d = 1'b0;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wdog_cnt_q <= '0;
            wdog_to_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_to_q  <= wdog_to_d;
        end
    end

    // A tripped watchdog idles the motors by loading the reset pulse width.
    assign ctrl_rd  = reg_q[0] | {wdog_to_q, 31'd0};
    assign pul_src0 = wdog_to_q ? RST_PULSE : reg_q[2];
    assign pul_src1 = wdog_to_q ? RST_PULSE : reg_q[3];
`else
    assign ctrl_rd  = reg_q[0];
    assign pul_src0 = reg_q[2];
    assign pul_src1 = reg_q[3];
    wire unused_wdog = ^WDOG_CYCLES;
`endif

    // A fresh start (enable edge or no valid shadow) uses the live registers
    always_comb begin
        en       = reg_q[0][0];
        en_rise  = en && !en_q;
        run      = en && (reg_q[1] != 32'd0);
        fresh    = en_rise || (sh_per_q == 32'd0);
        per_now  = fresh ? reg_q[1] : sh_per_q;
        pul0_now = fresh ? pul_src0 : sh_pul0_q;
        pul1_now = fresh ? pul_src1 : sh_pul1_q;
        wrap     = (per_now == 32'd0) || (cnt_q >= per_now - 32'd1);
        load     = en_rise || (run && wrap);
        en_d     = en;
        cnt_d    = '0;
        pwm_d    = 2'b00;
        if (run) begin
            cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
            pwm_d = {cnt_q < pul1_now, cnt_q < pul0_now};
        end
        sh_per_d  = load ? reg_q[1] : sh_per_q;
        sh_pul0_d = load ? pul_src0 : sh_pul0_q;
        sh_pul1_d = load ? pul_src1 : sh_pul1_q;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            reg_q[0]  <= '0;
            reg_q[1]  <= RST_PERIOD;
            reg_q[2]  <= RST_PULSE;
            reg_q[3]  <= RST_PULSE;
            cnt_q     <= '0;
            sh_per_q  <= RST_PERIOD;
            sh_pul0_q <= RST_PULSE;
            sh_pul1_q <= RST_PULSE;
            en_q      <= 1'b0;
            pwm_q     <= 2'b00;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
            cnt_q     <= cnt_d;
            sh_per_q  <= sh_per_d;
            sh_pul0_q <= sh_pul0_d;
            sh_pul1_q <= sh_pul1_d;
            en_q      <= en_d;
            pwm_q     <= pwm_d;
        end
    end
endmodule

// File: tb/tb_esc_pwm_axi_slave.sv
// Directed bench for esc_pwm_axi_slave: AXI register access and PWM timing.
// Expected values are hand-computed constants.
module tb_esc_pwm_axi_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] esc_pwm;
    int         n_vec = 0;
    int         n_err = 0;
    int         runs[$];
    int         run_len = 0;

    always #5 clk = ~clk;

    esc_pwm_axi_slave_if #(.AW(4)) ax();

    esc_pwm_axi_slave dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .axi           (ax),
        .esc_pwm       (esc_pwm)
    );

    // high-run lengths of channel 0
    always @(negedge clk) begin
        if (esc_pwm[0]) run_len++;
        else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int   t;
        logic aw_hs, w_hs;
        @(posedge clk); #1;
        ax.s_axi_awaddr  = a;
        ax.s_axi_awvalid = 1'b1;
        ax.s_axi_wdata   = d;
        ax.s_axi_wstrb   = s;
        ax.s_axi_wvalid  = 1'b1;
        t = 0;
        while ((ax.s_axi_awvalid || ax.s_axi_wvalid) && t < 20) begin
            @(negedge clk);
            aw_hs = ax.s_axi_awvalid && ax.s_axi_awready;
            w_hs  = ax.s_axi_wvalid && ax.s_axi_wready;
            @(posedge clk); #1;
            if (aw_hs) ax.s_axi_awvalid = 1'b0;
            if (w_hs) ax.s_axi_wvalid = 1'b0;
            t++;
        end
        ax.s_axi_awvalid = 1'b0;
        ax.s_axi_wvalid  = 1'b0;
        ax.s_axi_bready  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ax.s_axi_bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("wr_bvalid", {31'd0, ax.s_axi_bvalid}, 32'd1);
        chk("wr_bresp", {30'd0, ax.s_axi_bresp}, 32'd0);
        @(posedge clk); #1;
        ax.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int t;
        @(posedge clk); #1;
        ax.s_axi_araddr  = a;
        ax.s_axi_arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ax.s_axi_arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        ax.s_axi_arvalid = 1'b0;
        ax.s_axi_rready  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ax.s_axi_rvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rd_rvalid", {31'd0, ax.s_axi_rvalid}, 32'd1);
        chk("rd_rresp", {30'd0, ax.s_axi_rresp}, 32'd0);
        d = ax.s_axi_rdata;
        @(posedge clk); #1;
        ax.s_axi_rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] wv [4];
    logic [1:0]  acc;
    int          h0, h1, t;
    logic        prev;

    initial begin
        ax.s_axi_awaddr  = '0;
        ax.s_axi_awprot  = '0;
        ax.s_axi_awvalid = 1'b0;
        ax.s_axi_wdata   = '0;
        ax.s_axi_wstrb   = '0;
        ax.s_axi_wvalid  = 1'b0;
        ax.s_axi_bready  = 1'b0;
        ax.s_axi_araddr  = '0;
        ax.s_axi_arprot  = '0;
        ax.s_axi_arvalid = 1'b0;
        ax.s_axi_rready  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {29'd0, ax.s_axi_awready, ax.s_axi_wready, ax.s_axi_arready}, 32'd0);
        chk("rst_valid", {30'd0, ax.s_axi_bvalid, ax.s_axi_rvalid}, 32'd0);
        chk("rst_rdata", ax.s_axi_rdata, 32'd0);
        chk("rst_pwm", {30'd0, esc_pwm}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(4'h0, rd); chk("rst_ctrl", rd, 32'd0);
        axi_read(4'h4, rd); chk("rst_period", rd, 32'd1000000);
        axi_read(4'h8, rd); chk("rst_pulse0", rd, 32'd50000);

        // byte-lane write: only lane 1 of 0x0000C350 changes
        axi_write(4'h8, 32'hFFFF_FFFF, 4'b0010);
        axi_read(4'h8, rd); chk("wstrb_lane1", rd, 32'h0000_FF50);

        // full-word write/readback of each register
        wv[0] = 32'h0101_FFFF;
        wv[1] = 32'hABCD_0001;
        wv[2] = 32'hDEAD_0011;
        wv[3] = 32'hBEEF_0011;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), wv[i], 4'hF);
            axi_read(4'(i * 4), rd);
            chk($sformatf("rb_%0d", i), rd, wv[i]);
        end

        // W three clocks ahead of AW, bready held low
        @(posedge clk); #1;
        ax.s_axi_wdata  = 32'h1234_5678;
        ax.s_axi_wstrb  = 4'hF;
        ax.s_axi_wvalid = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", {31'd0, ax.s_axi_wready}, 32'd1);
        @(posedge clk); #1;
        ax.s_axi_wvalid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        ax.s_axi_awaddr  = 4'hC;
        ax.s_axi_awvalid = 1'b1;
        @(negedge clk);
        chk("wfirst_awready", {31'd0, ax.s_axi_awready}, 32'd1);
        chk("wfirst_no_b", {31'd0, ax.s_axi_bvalid}, 32'd0);
        @(posedge clk); #1;
        ax.s_axi_awvalid = 1'b0;
        @(negedge clk);
        chk("b_not_early", {31'd0, ax.s_axi_bvalid}, 32'd0);
        @(negedge clk);
        chk("b_rise", {31'd0, ax.s_axi_bvalid}, 32'd1);
        acc = 2'b11;
        repeat (3) begin
            @(negedge clk);
            acc[0] = acc[0] & ax.s_axi_bvalid;
        end
        chk("b_hold", {30'd0, acc}, 32'd3);
        @(posedge clk); #1;
        ax.s_axi_bready = 1'b1;
        @(negedge clk);
        chk("b_at_ready", {31'd0, ax.s_axi_bvalid}, 32'd1);
        @(posedge clk); #1;
        ax.s_axi_bready = 1'b0;
        @(negedge clk);
        chk("b_drop", {31'd0, ax.s_axi_bvalid}, 32'd0);
        axi_read(4'hC, rd); chk("wfirst_rb", rd, 32'h1234_5678);

        // PWM: period 100, pulse0 25, pulse1 100
        axi_write(4'h0, 32'd0, 4'hF);
        axi_write(4'h4, 32'd100, 4'hF);
        axi_write(4'h8, 32'd25, 4'hF);
        axi_write(4'hC, 32'd100, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        repeat (20) @(negedge clk);
        h0 = 0;
        h1 = 0;
        repeat (100) begin
            @(negedge clk);
            h0 += int'(esc_pwm[0]);
            h1 += int'(esc_pwm[1]);
        end
        chk("pwm0_duty", h0, 32'd25);
        chk("pwm1_duty", h1, 32'd100);

        // PULSE0 rewritten during a pulse takes effect next period
        prev = 1'b1;
        t = 0;
        while (t < 300) begin
            @(negedge clk);
            if (esc_pwm[0] && !prev) break;
            prev = esc_pwm[0];
            t++;
        end
        runs.delete();
        axi_write(4'h8, 32'd60, 4'hF);
        t = 0;
        while (runs.size() < 2 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("runs_seen", runs.size(), 32'd2);
        if (runs.size() >= 2) begin
            chk("pulse_cur", runs[0], 32'd25);
            chk("pulse_next", runs[1], 32'd60);
        end

        // PERIOD=0 silences both outputs
        axi_write(4'h4, 32'd0, 4'hF);
        acc = 2'b00;
        repeat (50) begin
            @(negedge clk);
            acc = acc | esc_pwm;
        end
        chk("period0_pwm", {30'd0, acc}, 32'd0);

        // reset while bvalid is pending
        axi_write(4'h4, 32'd100, 4'hF);
        repeat (5) @(negedge clk);
        chk("pwm1_running", {31'd0, esc_pwm[1]}, 32'd1);
        @(posedge clk); #1;
        ax.s_axi_awaddr  = 4'h8;
        ax.s_axi_awvalid = 1'b1;
        ax.s_axi_wdata   = 32'h77;
        ax.s_axi_wstrb   = 4'hF;
        ax.s_axi_wvalid  = 1'b1;
        @(posedge clk); #1;
        ax.s_axi_awvalid = 1'b0;
        ax.s_axi_wvalid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pend_bvalid", {31'd0, ax.s_axi_bvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bvalid", {31'd0, ax.s_axi_bvalid}, 32'd0);
        chk("arst_pwm", {30'd0, esc_pwm}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_bvalid", {31'd0, ax.s_axi_bvalid}, 32'd0);
        axi_read(4'h0, rd); chk("post_ctrl", rd, 32'd0);
        axi_read(4'h4, rd); chk("post_period", rd, 32'd1000000);
        axi_read(4'h8, rd); chk("post_pulse0", rd, 32'd50000);
        axi_read(4'hC, rd); chk("post_pulse1", rd, 32'd50000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
